// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, LRU replacement and flush.
// Misses fetch a whole block sequentially from the memory controller before the line turns valid.
module icache_assoc #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned CPUID       = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr
);

  localparam int unsigned WB    = $clog2(BLOCK_WORDS);
  localparam int unsigned IB    = $clog2(SETS);
  localparam int unsigned TBITS = 30 - WB - IB;
  localparam int unsigned OW    = (WB > 0) ? WB : 1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      cnt_q, cnt_d;
  logic [TBITS-1:0]   ftag_q, ftag_d;
  logic [IB-1:0]      fidx_q, fidx_d;
  logic               vic_q, vic_d;

  logic               valid_q [WAYS][SETS];
  logic               lru_q   [SETS];
  logic [TBITS-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]        data_q  [WAYS][SETS][BLOCK_WORDS];

  logic [31:0]        word_addr;
  logic [OW-1:0]      off;
  logic [IB-1:0]      idx;
  logic [TBITS-1:0]   tag;
  logic               hit_any, hit_way, victim;
  logic               fill_we, fill_done;

  // Byte-offset bits and the core id carry no function.
  logic unused_bits;
  assign unused_bits = ^{imemaddr[1:0], 32'(CPUID)};

  assign word_addr = {2'b00, imemaddr[31:2]};
  assign off       = OW'(word_addr & (BLOCK_WORDS - 1));
  assign idx       = IB'(word_addr >> WB);
  assign tag       = TBITS'(word_addr >> (WB + IB));

  always_comb begin
    hit_any = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit_any = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  assign ihit     = imemREN && hit_any && (state_q == StIdle);
  assign imemload = hit_any ? data_q[hit_way][idx][off] : 32'h0;

  // Prefer the lowest invalid way; only a full set consults LRU.
  always_comb begin
    if (WAYS == 1)                      victim = 1'b0;
    else if (!valid_q[0][idx])          victim = 1'b0;
    else if (!valid_q[WAYS-1][idx])     victim = 1'(WAYS - 1);
    else                                victim = lru_q[idx];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ftag_d    = ftag_q;
    fidx_d    = fidx_q;
    vic_d     = vic_q;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    iREN      = 1'b0;
    iaddr     = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (imemREN && !hit_any && !iflush) begin
          state_d = StFill;
          ftag_d  = tag;
          fidx_d  = idx;
          cnt_d   = '0;
          vic_d   = victim;
        end
      end
      StFill: begin
        iREN  = 1'b1;
        iaddr = (32'(ftag_q) << (2 + WB + IB)) | (32'(fidx_q) << (2 + WB)) | (32'(cnt_q) << 2);
        if (iflush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!iwait) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OW'(1);
          if (32'(cnt_q) == BLOCK_WORDS - 1) begin
            fill_done = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ftag_q  <= '0;
      fidx_q  <= '0;
      vic_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ftag_q  <= ftag_d;
      fidx_q  <= fidx_d;
      vic_q   <= vic_d;
    end
  end

  // Flush outranks both hit-driven LRU updates and fill completion.
  always_ff @(posedge CLK) begin
    if (!nRST || iflush) begin
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      if (ihit) lru_q[idx] <= ~hit_way;
      if (fill_done) begin
        valid_q[vic_q][fidx_q] <= 1'b1;
        lru_q[fidx_q]          <= ~vic_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we && nRST) data_q[vic_q][fidx_q][cnt_q] <= iload;
    if (fill_done && nRST) tag_q[vic_q][fidx_q] <= ftag_q;
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios plus random traffic, all checked against a
// block-level cache model (sets of tagged lines, per-set LRU, one outstanding block fetch).
module tb_icache_assoc;
  localparam int unsigned SETS = 8;
  localparam int unsigned WAYS = 2;
  localparam int unsigned BW   = 2;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, iflush, iwait, ihit, iREN;
  logic [31:0] imemaddr, imemload, iload, iaddr, junk;
  logic        d1_ren, d1_ihit, d1_iren;
  logic [31:0] d1_addr, d1_load, d1_iload, d1_iaddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[31:2], 2'b00} + 32'h60;
  endfunction

  // Garbage on the bus while busy exposes any write taken during iwait.
  always @(posedge CLK) junk <= $urandom;
  always_comb iload = iwait ? junk : mem(iaddr);
  assign d1_iload = mem(d1_iaddr);

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLOCK_WORDS(BW), .CPUID(0)) u_dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload), .iREN(iREN), .iaddr(iaddr)
  );

  icache_assoc #(.SETS(SETS), .WAYS(1), .BLOCK_WORDS(BW), .CPUID(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .imemREN(d1_ren), .imemaddr(d1_addr), .iflush(1'b0),
    .ihit(d1_ihit), .imemload(d1_load), .iwait(1'b0), .iload(d1_iload), .iREN(d1_iren),
    .iaddr(d1_iaddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  bit          mv   [WAYS][SETS];
  logic [31:0] mtag [WAYS][SETS];
  logic [31:0] mdat [WAYS][SETS][BW];
  bit          mlru [SETS];
  bit          known = 0, filling = 0;
  int          f_idx, f_vic, f_cnt;
  logic [31:0] f_tag;
  logic [31:0] f_buf [BW];

  always @(negedge CLK) begin : model
    logic [31:0] word, tag;
    int idx, off, hw;
    bit anyh, e_hit;
    word = imemaddr >> 2;
    off  = int'(word % BW);
    idx  = int'((word / BW) % SETS);
    tag  = word / (BW * SETS);
    anyh = 0;
    hw   = 0;
    for (int w = 0; w < WAYS; w++)
      if (mv[w][idx] && mtag[w][idx] == tag) begin anyh = 1; hw = w; end
    e_hit = !filling && imemREN && anyh;
    if (known) begin
      chk("m_ihit", 32'(ihit), 32'(e_hit));
      chk("m_iREN", 32'(iREN), 32'(filling));
      chk("m_iaddr", iaddr, filling ? ((f_tag * SETS + 32'(f_idx)) * BW + 32'(f_cnt)) * 4 : 0);
      if (e_hit) chk("m_imemload", imemload, mdat[hw][idx][off]);
      else if (!filling && !anyh) chk("m_imemload_zero", imemload, 32'h0);
    end
    if (!nRST || iflush) begin
      for (int s = 0; s < SETS; s++) begin
        mlru[s] = 0;
        for (int w = 0; w < WAYS; w++) mv[w][s] = 0;
      end
      filling = 0;
      if (!nRST) known = 1;
    end else if (filling) begin
      if (!iwait) begin
        f_buf[f_cnt] = iload;
        f_cnt++;
        if (f_cnt == BW) begin
          mv[f_vic][f_idx]   = 1;
          mtag[f_vic][f_idx] = f_tag;
          for (int k = 0; k < BW; k++) mdat[f_vic][f_idx][k] = f_buf[k];
          mlru[f_idx] = (f_vic == 0);
          filling = 0;
        end
      end
    end else if (imemREN && !anyh) begin
      filling = 1;
      f_tag   = tag;
      f_idx   = idx;
      f_cnt   = 0;
      f_vic   = -1;
      for (int w = 0; w < WAYS; w++) if (!mv[w][idx] && f_vic < 0) f_vic = w;
      if (f_vic < 0) f_vic = int'(mlru[idx]);
    end else if (e_hit) begin
      mlru[idx] = (hw == 0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Full miss with zero wait: miss cycle, one cycle per word, then the hit.
  task automatic miss_fill(input logic [31:0] a);
    imemREN = 1; imemaddr = a; iwait = 0; iflush = 0;
    @(negedge CLK);
    chk("miss_ihit", 32'(ihit), 0);
    chk("miss_iREN", 32'(iREN), 0);
    for (int w = 0; w < BW; w++) begin
      step();
      @(negedge CLK);
      chk("fill_iREN", 32'(iREN), 1);
      chk("fill_iaddr", iaddr, a + 32'(4 * w));
    end
    step();
    @(negedge CLK);
    chk("fill_ihit", 32'(ihit), 1);
    chk("fill_load", imemload, mem(a));
  endtask

  task automatic probe(input logic [31:0] a, input bit exp);
    imemREN = 1; imemaddr = a;
    @(negedge CLK);
    chk("probe_ihit", 32'(ihit), 32'(exp));
    if (exp) chk("probe_load", imemload, mem(a));
    step();
  endtask

  task automatic wait_hit(input logic [31:0] a);
    int n = 0;
    imemREN = 1; imemaddr = a; iwait = 0;
    @(negedge CLK);
    while (!ihit && n < 20) begin step(); @(negedge CLK); n++; end
    chk("wait_hit", 32'(ihit), 1);
    step();
  endtask

  task automatic d1_fill(input logic [31:0] a);
    int n = 0;
    d1_ren = 1; d1_addr = a;
    @(negedge CLK);
    while (!d1_ihit && n < 20) begin step(); @(negedge CLK); n++; end
    chk("w1_fill_hit", 32'(d1_ihit), 1);
    chk("w1_fill_load", d1_load, mem(a));
    step();
  endtask

  initial begin
    nRST = 0; imemREN = 0; iflush = 0; iwait = 0; imemaddr = 0;
    d1_ren = 0; d1_addr = 0;
    step(); step();
    @(negedge CLK);
    chk("rst_ihit", 32'(ihit), 0);
    chk("rst_iREN", 32'(iREN), 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    step();
    nRST = 1;

    // Basic miss of 0x40 then hits on both words
    miss_fill(32'h40);
    chk("t1_load40", imemload, 32'hA0);
    step();
    imemaddr = 32'h44;
    @(negedge CLK);
    chk("t1_hit44", 32'(ihit), 1);
    chk("t1_load44", imemload, 32'hA4);
    step();

    // Same miss with three busy cycles per word
    iflush = 1; imemREN = 0;
    step();
    iflush = 0; imemREN = 1; imemaddr = 32'h40; iwait = 1;
    @(negedge CLK);
    chk("t2_miss", 32'(ihit), 0);
    step();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        iwait = (k < 3);
        @(negedge CLK);
        chk("t2_iaddr", iaddr, 32'h40 + 32'(4 * w));
        chk("t2_noh", 32'(ihit), 0);
        step();
      end
    end
    iwait = 0;
    @(negedge CLK);
    chk("t2_hit", 32'(ihit), 1);
    chk("t2_load", imemload, 32'hA0);
    step();
    probe(32'h44, 1);

    // Two ways in set 0, then LRU eviction
    miss_fill(32'h240);
    step();
    probe(32'h240, 1);
    probe(32'h40, 1);
    miss_fill(32'h440);
    step();
    probe(32'h40, 1);
    probe(32'h240, 0);
    wait_hit(32'h240);

    // Flush after the first word of a fill
    imemREN = 1; imemaddr = 32'h80; iwait = 0;
    @(negedge CLK);
    chk("t4_miss", 32'(ihit), 0);
    step();
    @(negedge CLK);
    chk("t4_iaddr0", iaddr, 32'h80);
    step();
    iflush = 1;
    @(negedge CLK);
    chk("t4_iaddr1", iaddr, 32'h84);
    step();
    iflush = 0; imemREN = 0;
    @(negedge CLK);
    chk("t4_iren_off", 32'(iREN), 0);
    step();
    probe(32'h40, 0);
    wait_hit(32'h40);
    miss_fill(32'h80);
    step();

    // Fill completes after the request goes away
    iflush = 1; imemREN = 0;
    step();
    iflush = 0; imemREN = 1; imemaddr = 32'h80;
    @(negedge CLK);
    chk("t5_miss", 32'(ihit), 0);
    step();
    imemaddr = 32'h100; imemREN = 0;
    @(negedge CLK);
    chk("t5_iaddr0", iaddr, 32'h80);
    step();
    @(negedge CLK);
    chk("t5_iaddr1", iaddr, 32'h84);
    step();
    @(negedge CLK);
    chk("t5_done", 32'(iREN), 0);
    probe(32'h80, 1);

    // Reset in the middle of a fill
    imemREN = 1; imemaddr = 32'h100;
    @(negedge CLK);
    chk("t6_miss", 32'(ihit), 0);
    step();
    nRST = 0;
    @(negedge CLK);
    chk("t6_filling", 32'(iREN), 1);
    step();
    nRST = 1; imemREN = 0;
    @(negedge CLK);
    chk("t6_iren_off", 32'(iREN), 0);
    step();
    probe(32'h80, 0);
    wait_hit(32'h80);

    // Random traffic over a small address pool so sets conflict often
    repeat (3000) begin
      nRST     = !($urandom_range(0, 199) == 0);
      iflush   = ($urandom_range(0, 49) == 0);
      imemREN  = ($urandom_range(0, 9) < 8);
      iwait    = ($urandom_range(0, 9) < 3);
      imemaddr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 3) |
                 (32'($urandom_range(0, 1)) << 2);
      step();
    end
    nRST = 1; iflush = 0; imemREN = 0; iwait = 0;
    repeat (4) step();

    // Direct-mapped build: conflicting block evicts the first
    d1_fill(32'h40);
    d1_fill(32'h240);
    d1_addr = 32'h40;
    @(negedge CLK);
    chk("w1_evicted", 32'(d1_ihit), 0);
    step();
    d1_ren = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
